// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register
// sentinel and the pipeline-register bubble value.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    // Contents of the decode-side pipeline register.
    typedef struct packed {
        stat_t       stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_reg_t;

    localparam logic [3:0]  BUBBLE_ICODE = I_NOP;
    localparam logic [3:0]  BUBBLE_IFUN  = 4'h0;
    localparam logic [63:0] BUBBLE_VALC  = 64'h0;
    localparam logic [63:0] BUBBLE_VALP  = 64'h0;

    localparam d_reg_t D_BUBBLE = '{
        stat:  STAT_AOK,
        icode: BUBBLE_ICODE,
        ifun:  BUBBLE_IFUN,
        ra:    REG_NONE,
        rb:    REG_NONE,
        valc:  BUBBLE_VALC,
        valp:  BUBBLE_VALP
    };

    // Instructions carrying a register-specifier byte.
    function automatic logic need_regids_f(input logic [3:0] icode);
        return icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                             I_OPQ, I_PUSHQ, I_POPQ};
    endfunction

    // Instructions carrying an 8-byte constant.
    function automatic logic need_valc_f(input logic [3:0] icode);
        return icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
    endfunction

endpackage

// File: rtl/fetch_split_align.sv
// Combinational instruction split/align: pulls icode/ifun/registers out of
// the fetched bytes, extracts the little-endian constant and computes the
// sequential and predicted next PC.
module fetch_split_align
    import y86_pkg::*;
(
    input  logic [63:0] f_pc,
    input  logic [79:0] imem_data,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valc,
    output logic [63:0] valp,
    output logic [63:0] pred_pc
);

    logic need_regids;
    logic need_valc;

    // Split byte 0, decide instruction length and pick the constant field.
    always_comb begin
        icode       = imem_data[7:4];
        ifun        = imem_data[3:0];
        need_regids = need_regids_f(imem_data[7:4]);
        need_valc   = need_valc_f(imem_data[7:4]);

        ra = REG_NONE;
        rb = REG_NONE;
        if (need_regids) begin
            ra = imem_data[15:12];
            rb = imem_data[11:8];
        end

        // Bit order of imem_data already matches little-endian byte order,
        // so the constant is a plain slice starting at byte 1 or byte 2.
        valc = 64'h0;
        if (need_valc) begin
            valc = need_regids ? imem_data[79:16] : imem_data[71:8];
        end
    end

    // Sequential PC wraps silently at 2^64; jumps and calls predict taken.
    always_comb begin
        valp = f_pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
        if (icode == I_JXX || icode == I_CALL) begin
            pred_pc = valc;
        end else begin
            pred_pc = valp;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: F register (predicted PC), fetch-PC selection,
// D-register fields, load/use / ret / mispredict hazard control and the
// sticky fetch-halt flag.
module fetch_stage
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
)
(
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_data,
    input  logic        imem_error,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_dstM,
    input  logic        e_Cnd,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [1:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic        E_bubble,
    output logic        halted
);

    logic [63:0] f_pred_pc;
    logic [63:0] f_pc;

    logic [3:0]  split_icode;
    logic [3:0]  split_ifun;
    logic [3:0]  split_ra;
    logic [3:0]  split_rb;
    logic [63:0] split_valc;
    logic [63:0] split_valp;
    logic [63:0] split_pred_pc;

    stat_t       f_stat;
    d_reg_t      f_d;
    d_reg_t      d_q;
    logic        halted_q;

    logic        load_use;
    logic        ret_in;
    logic        mispred;
    logic        f_stall;
    logic        d_stall;
    logic        d_bubble;

    // Fetch PC: a not-taken jump in M wins over a returning ret in W.
    always_comb begin
        if (M_icode == I_JXX && !M_Cnd) begin
            f_pc = M_valA;
        end else if (W_icode == I_RET) begin
            f_pc = W_valM;
        end else begin
            f_pc = f_pred_pc;
        end
    end

    assign imem_addr = f_pc;

    fetch_split_align u_split (
        .f_pc      (f_pc),
        .imem_data (imem_data),
        .icode     (split_icode),
        .ifun      (split_ifun),
        .ra        (split_ra),
        .rb        (split_rb),
        .valc      (split_valc),
        .valp      (split_valp),
        .pred_pc   (split_pred_pc)
    );

    // Fetch status and the field set offered to the D register.
    always_comb begin
        if (imem_error) begin
            f_stat = STAT_ADR;
        end else if (split_icode > I_POPQ) begin
            f_stat = STAT_INS;
        end else if (split_icode == I_HALT) begin
            f_stat = STAT_HLT;
        end else begin
            f_stat = STAT_AOK;
        end

        f_d       = D_BUBBLE;
        f_d.stat  = f_stat;
        f_d.icode = split_icode;
        f_d.ifun  = split_ifun;
        f_d.ra    = split_ra;
        f_d.rb    = split_rb;
        f_d.valc  = split_valc;
        f_d.valp  = split_valp;
        // Bytes from a bad address are meaningless; pass a clean NOP down.
        if (f_stat == STAT_ADR) begin
            f_d.icode = I_NOP;
            f_d.ifun  = 4'h0;
        end
    end

    // Hazard detection and the resulting stall/bubble controls.
    always_comb begin
        load_use = (E_icode == I_MRMOVQ || E_icode == I_POPQ) &&
                   (E_dstM != REG_NONE) &&
                   (E_dstM == d_srcA || E_dstM == d_srcB);
        ret_in   = (d_q.icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispred  = (E_icode == I_JXX) && !e_Cnd;

        f_stall  = load_use || ret_in || halted_q;
        d_stall  = load_use;
        d_bubble = mispred || (ret_in && !load_use) || (halted_q && !load_use);
    end

    assign E_bubble = mispred || load_use;

    // F register: predicted PC, frozen while fetch is stalled or halted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pred_pc <= RESET_PC;
        end else if (!f_stall) begin
            f_pred_pc <= split_pred_pc;
        end
    end

    // D register: stall holds, bubble clears, otherwise take fetched fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= D_BUBBLE;
        end else if (!d_stall) begin
            if (d_bubble) begin
                d_q <= D_BUBBLE;
            end else begin
                d_q <= f_d;
            end
        end
    end

    // Halt flag: set when a faulting fetch actually enters D; a mispredict
    // proves that fetch was on the wrong path, so it releases the halt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else if (mispred) begin
            halted_q <= 1'b0;
        end else if (!d_stall && !d_bubble && f_stat != STAT_AOK) begin
            halted_q <= 1'b1;
        end
    end

    assign D_stat  = d_q.stat;
    assign D_icode = d_q.icode;
    assign D_ifun  = d_q.ifun;
    assign D_rA    = d_q.ra;
    assign D_rB    = d_q.rb;
    assign D_valC  = d_q.valc;
    assign D_valP  = d_q.valp;
    assign halted  = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run against a byte-level behavioural model of fetch and hazard control.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error;
    logic [3:0]  d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic        e_Cnd, M_Cnd;
    logic [63:0] M_valA, W_valM;
    logic [1:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        E_bubble, halted;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [79:0] IRMOVQ_100 = 80'h0000_0000_0000_0100_F030;
    localparam logic [79:0] JXX_40     = 80'h0000_0000_0000_0000_4070;
    localparam logic [79:0] NOP_BYTES  = 80'h10;

    logic [3:0] e_pool [8] = '{4'h1, 4'h5, 4'h7, 4'h9, 4'hB, 4'h2, 4'h3, 4'h6};
    logic [3:0] m_pool [8] = '{4'h1, 4'h1, 4'h7, 4'h9, 4'h3, 4'h6, 4'h1, 4'h2};
    logic [3:0] w_pool [8] = '{4'h1, 4'h1, 4'h9, 4'h3, 4'h6, 4'h1, 4'h2, 4'h5};

    fetch_stage #(.RESET_PC(64'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_error (imem_error),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .E_icode    (E_icode),
        .E_dstM     (E_dstM),
        .e_Cnd      (e_Cnd),
        .M_icode    (M_icode),
        .M_Cnd      (M_Cnd),
        .M_valA     (M_valA),
        .W_icode    (W_icode),
        .W_valM     (W_valM),
        .D_stat     (D_stat),
        .D_icode    (D_icode),
        .D_ifun     (D_ifun),
        .D_rA       (D_rA),
        .D_rB       (D_rB),
        .D_valC     (D_valC),
        .D_valP     (D_valP),
        .E_bubble   (E_bubble),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        imem_data  = NOP_BYTES;
        imem_error = 1'b0;
        d_srcA     = 4'hF;
        d_srcB     = 4'hF;
        E_icode    = 4'h1;
        E_dstM     = 4'hF;
        e_Cnd      = 1'b1;
        M_icode    = 4'h1;
        M_Cnd      = 1'b1;
        M_valA     = 64'h0;
        W_icode    = 4'h1;
        W_valM     = 64'h0;
    endtask

    task automatic apply_reset();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        #1;
        n_checks++; if (D_icode !== 4'h1) begin n_fail++; $display("FAIL reset_icode: got %0h want 1", D_icode); end
        n_checks++; if (D_stat !== 2'd0) begin n_fail++; $display("FAIL reset_stat: got %0d want 0", D_stat); end
        n_checks++; if (D_rA !== 4'hF || D_rB !== 4'hF) begin n_fail++; $display("FAIL reset_regs: got %0h/%0h want f/f", D_rA, D_rB); end
        n_checks++; if (D_valC !== 64'h0 || D_valP !== 64'h0) begin n_fail++; $display("FAIL reset_vals: got %0h/%0h want 0/0", D_valC, D_valP); end
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (imem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", imem_addr); end
        n_checks++; if (halted !== 1'b0 || E_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got halted=%0b ebub=%0b want 0/0", halted, E_bubble); end
    endtask

    task automatic test_irmovq();
        apply_reset();
        imem_data = IRMOVQ_100;
        tick();
        n_checks++; if (D_icode !== 4'h3 || D_ifun !== 4'h0) begin n_fail++; $display("FAIL irmovq_code: got %0h%0h want 30", D_icode, D_ifun); end
        n_checks++; if (D_rA !== 4'hF || D_rB !== 4'h0) begin n_fail++; $display("FAIL irmovq_regs: got %0h/%0h want f/0", D_rA, D_rB); end
        n_checks++; if (D_valC !== 64'h100) begin n_fail++; $display("FAIL irmovq_valc: got %0h want 100", D_valC); end
        n_checks++; if (D_valP !== 64'hA) begin n_fail++; $display("FAIL irmovq_valp: got %0h want a", D_valP); end
        n_checks++; if (imem_addr !== 64'hA) begin n_fail++; $display("FAIL irmovq_next_pc: got %0h want a", imem_addr); end
    endtask

    task automatic test_jxx_mispredict();
        apply_reset();
        imem_data = JXX_40;
        tick();
        n_checks++; if (D_icode !== 4'h7 || D_valC !== 64'h40 || D_valP !== 64'h9) begin n_fail++; $display("FAIL jxx_fields: got icode=%0h valc=%0h valp=%0h want 7/40/9", D_icode, D_valC, D_valP); end
        n_checks++; if (imem_addr !== 64'h40) begin n_fail++; $display("FAIL jxx_pred_pc: got %0h want 40", imem_addr); end
        imem_data = NOP_BYTES;
        E_icode   = 4'h7;
        e_Cnd     = 1'b0;
        #1;
        n_checks++; if (E_bubble !== 1'b1) begin n_fail++; $display("FAIL mispred_ebubble: got %0b want 1", E_bubble); end
        tick();
        n_checks++; if (D_icode !== 4'h1 || D_valP !== 64'h0) begin n_fail++; $display("FAIL mispred_dbubble: got icode=%0h valp=%0h want 1/0", D_icode, D_valP); end
        E_icode = 4'h1;
        e_Cnd   = 1'b1;
        M_icode = 4'h7;
        M_Cnd   = 1'b0;
        M_valA  = 64'h9;
        #1;
        n_checks++; if (imem_addr !== 64'h9) begin n_fail++; $display("FAIL mispred_fix_pc: got %0h want 9", imem_addr); end
    endtask

    task automatic test_load_use();
        apply_reset();
        imem_data = IRMOVQ_100;
        tick();
        imem_data = NOP_BYTES;
        E_icode   = 4'h5;
        E_dstM    = 4'h3;
        d_srcA    = 4'h3;
        #1;
        n_checks++; if (E_bubble !== 1'b1) begin n_fail++; $display("FAIL loaduse_ebubble: got %0b want 1", E_bubble); end
        tick();
        n_checks++; if (D_icode !== 4'h3 || D_valC !== 64'h100 || D_valP !== 64'hA) begin n_fail++; $display("FAIL loaduse_dhold: got icode=%0h valc=%0h valp=%0h want 3/100/a", D_icode, D_valC, D_valP); end
        n_checks++; if (imem_addr !== 64'hA) begin n_fail++; $display("FAIL loaduse_fhold: got %0h want a", imem_addr); end
        E_dstM = 4'hF;
        d_srcA = 4'hF;
        #1;
        n_checks++; if (E_bubble !== 1'b0) begin n_fail++; $display("FAIL loaduse_none_reg: got %0b want 0", E_bubble); end
        tick();
        n_checks++; if (D_icode !== 4'h1 || D_valP !== 64'hB || imem_addr !== 64'hB) begin n_fail++; $display("FAIL loaduse_release: got icode=%0h valp=%0h pc=%0h want 1/b/b", D_icode, D_valP, imem_addr); end
    endtask

    task automatic test_ret();
        int bubbles;
        apply_reset();
        imem_data = 80'h90;
        tick();
        imem_data = NOP_BYTES;
        n_checks++; if (D_icode !== 4'h9 || D_valP !== 64'h1) begin n_fail++; $display("FAIL ret_fetch: got icode=%0h valp=%0h want 9/1", D_icode, D_valP); end
        bubbles = 0;
        tick();
        if (D_icode === 4'h1 && D_valP === 64'h0 && imem_addr === 64'h1) bubbles++;
        E_icode = 4'h9;
        tick();
        if (D_icode === 4'h1 && D_valP === 64'h0 && imem_addr === 64'h1) bubbles++;
        E_icode = 4'h1;
        M_icode = 4'h9;
        tick();
        if (D_icode === 4'h1 && D_valP === 64'h0) bubbles++;
        n_checks++; if (bubbles != 3) begin n_fail++; $display("FAIL ret_bubbles: got %0d frozen bubble cycles want 3", bubbles); end
        M_icode = 4'h1;
        W_icode = 4'h9;
        W_valM  = 64'h80;
        #1;
        n_checks++; if (imem_addr !== 64'h80) begin n_fail++; $display("FAIL ret_target: got %0h want 80", imem_addr); end
        tick();
        W_icode = 4'h1;
        #1;
        n_checks++; if (D_valP !== 64'h81 || imem_addr !== 64'h81) begin n_fail++; $display("FAIL ret_resume: got valp=%0h pc=%0h want 81/81", D_valP, imem_addr); end
    endtask

    task automatic test_imem_error();
        apply_reset();
        imem_error = 1'b1;
        imem_data  = 80'h0000_0000_0000_0000_F030;
        tick();
        imem_error = 1'b0;
        imem_data  = NOP_BYTES;
        n_checks++; if (D_stat !== 2'd2 || D_icode !== 4'h1 || D_ifun !== 4'h0) begin n_fail++; $display("FAIL adr_fields: got stat=%0d icode=%0h ifun=%0h want 2/1/0", D_stat, D_icode, D_ifun); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL adr_halted: got %0b want 1", halted); end
        tick();
        n_checks++; if (D_stat !== 2'd0 || D_icode !== 4'h1 || D_valP !== 64'h0 || imem_addr !== 64'hA) begin n_fail++; $display("FAIL adr_frozen: got stat=%0d icode=%0h valp=%0h pc=%0h want 0/1/0/a", D_stat, D_icode, D_valP, imem_addr); end
        E_icode = 4'h7;
        e_Cnd   = 1'b0;
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL adr_clear: got %0b want 0", halted); end
        E_icode = 4'h1;
        e_Cnd   = 1'b1;
        M_icode = 4'h7;
        M_Cnd   = 1'b0;
        M_valA  = 64'h200;
        #1;
        n_checks++; if (imem_addr !== 64'h200) begin n_fail++; $display("FAIL adr_resume_pc: got %0h want 200", imem_addr); end
        tick();
        n_checks++; if (D_icode !== 4'h1 || D_valP !== 64'h201) begin n_fail++; $display("FAIL adr_resume_d: got icode=%0h valp=%0h want 1/201", D_icode, D_valP); end
    endtask

    task automatic test_ins_hlt();
        apply_reset();
        imem_data = 80'hC0;
        tick();
        n_checks++; if (D_stat !== 2'd3 || D_icode !== 4'hC || halted !== 1'b1) begin n_fail++; $display("FAIL ins: got stat=%0d icode=%0h halted=%0b want 3/c/1", D_stat, D_icode, halted); end
        apply_reset();
        imem_data = 80'h00;
        tick();
        imem_data = NOP_BYTES;
        n_checks++; if (D_stat !== 2'd1 || D_icode !== 4'h0 || halted !== 1'b1) begin n_fail++; $display("FAIL hlt: got stat=%0d icode=%0h halted=%0b want 1/0/1", D_stat, D_icode, halted); end
        tick();
        n_checks++; if (D_stat !== 2'd0 || D_icode !== 4'h1 || imem_addr !== 64'h1) begin n_fail++; $display("FAIL hlt_after: got stat=%0d icode=%0h pc=%0h want 0/1/1", D_stat, D_icode, imem_addr); end
    endtask

    task automatic test_valp_wrap();
        apply_reset();
        imem_data = IRMOVQ_100;
        W_icode   = 4'h9;
        W_valM    = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        W_icode = 4'h1;
        #1;
        n_checks++; if (D_valP !== 64'h8 || imem_addr !== 64'h8) begin n_fail++; $display("FAIL valp_wrap: got valp=%0h pc=%0h want 8/8", D_valP, imem_addr); end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        imem_data = IRMOVQ_100;
        tick();
        imem_data = NOP_BYTES;
        E_icode   = 4'h5;
        E_dstM    = 4'h3;
        d_srcB    = 4'h3;
        tick();
        #2;
        reset = 1'b1;
        tick();
        n_checks++; if (D_icode !== 4'h1 || D_valC !== 64'h0 || D_rB !== 4'hF || imem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_mid_stall: got icode=%0h valc=%0h rb=%0h pc=%0h want 1/0/f/0", D_icode, D_valC, D_rB, imem_addr); end
        reset = 1'b0;
        set_idle();
    endtask

    task automatic test_random(input int n_cycles);
        logic [7:0]  b [10];
        logic [63:0] m_pred, fpc, vc, vp, np;
        logic [1:0]  m_stat, st;
        logic [3:0]  m_icode, m_ifun, m_ra, m_rb, ic, fi, ff, ra, rb;
        logic [63:0] m_valc, m_valp;
        logic        m_halted, regs, hasc, lu, rt, mp, fstall, dbub;
        int          r, off;
        apply_reset();
        m_pred = 64'h0; m_stat = 2'd0; m_icode = 4'h1; m_ifun = 4'h0;
        m_ra = 4'hF; m_rb = 4'hF; m_valc = 64'h0; m_valp = 64'h0; m_halted = 1'b0;
        for (int c = 0; c < n_cycles; c++) begin
            for (int k = 0; k < 10; k++) b[k] = 8'($urandom);
            r = $urandom_range(0, 99);
            if (r < 4)      b[0][7:4] = 4'h0;
            else if (r < 8) b[0][7:4] = 4'($urandom_range(12, 15));
            else            b[0][7:4] = 4'($urandom_range(1, 11));
            for (int k = 0; k < 10; k++) imem_data[8*k +: 8] = b[k];
            imem_error = ($urandom_range(0, 29) == 0);
            E_icode = e_pool[$urandom_range(0, 7)];
            E_dstM  = 4'($urandom_range(0, 15));
            d_srcA  = ($urandom_range(0, 2) == 0) ? E_dstM : 4'($urandom_range(0, 15));
            d_srcB  = 4'($urandom_range(0, 15));
            e_Cnd   = 1'($urandom_range(0, 1));
            M_icode = m_pool[$urandom_range(0, 7)];
            M_Cnd   = 1'($urandom_range(0, 1));
            M_valA  = {32'($urandom), 32'($urandom)};
            W_icode = w_pool[$urandom_range(0, 7)];
            W_valM  = {32'($urandom), 32'($urandom)};

            if (M_icode == 4'h7 && !M_Cnd) fpc = M_valA;
            else if (W_icode == 4'h9)     fpc = W_valM;
            else                          fpc = m_pred;
            ic   = b[0][7:4];
            regs = ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
            hasc = ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
            off  = regs ? 2 : 1;
            vc   = 64'h0;
            if (hasc) for (int k = 0; k < 8; k++) vc = vc | (64'(b[off + k]) << (8 * k));
            vp   = fpc + 64'd1 + (regs ? 64'd1 : 64'd0) + (hasc ? 64'd8 : 64'd0);
            np   = (ic == 4'h7 || ic == 4'h8) ? vc : vp;
            st   = imem_error ? 2'd2 : (ic > 4'hB) ? 2'd3 : (ic == 4'h0) ? 2'd1 : 2'd0;
            fi   = (st == 2'd2) ? 4'h1 : ic;
            ff   = (st == 2'd2) ? 4'h0 : b[0][3:0];
            ra   = regs ? b[1][7:4] : 4'hF;
            rb   = regs ? b[1][3:0] : 4'hF;
            lu   = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF && (E_dstM == d_srcA || E_dstM == d_srcB);
            rt   = (m_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
            mp   = (E_icode == 4'h7) && !e_Cnd;
            #1;
            n_checks++; if (imem_addr !== fpc) begin n_fail++; $display("FAIL rand_pc c=%0d: got %0h want %0h", c, imem_addr, fpc); end
            n_checks++; if (E_bubble !== (mp || lu)) begin n_fail++; $display("FAIL rand_ebubble c=%0d: got %0b want %0b", c, E_bubble, (mp || lu)); end
            tick();
            fstall = lu || rt || m_halted;
            dbub   = mp || (rt && !lu) || (m_halted && !lu);
            if (mp) m_halted = 1'b0;
            else if (!lu && !dbub && st != 2'd0) m_halted = 1'b1;
            if (!lu) begin
                if (dbub) begin
                    m_stat = 2'd0; m_icode = 4'h1; m_ifun = 4'h0; m_ra = 4'hF; m_rb = 4'hF; m_valc = 64'h0; m_valp = 64'h0;
                end else begin
                    m_stat = st; m_icode = fi; m_ifun = ff; m_ra = ra; m_rb = rb; m_valc = vc; m_valp = vp;
                end
            end
            if (!fstall) m_pred = np;
            n_checks++; if (D_stat !== m_stat || D_icode !== m_icode || D_ifun !== m_ifun) begin n_fail++; $display("FAIL rand_dcode c=%0d: got %0d/%0h/%0h want %0d/%0h/%0h", c, D_stat, D_icode, D_ifun, m_stat, m_icode, m_ifun); end
            n_checks++; if (D_rA !== m_ra || D_rB !== m_rb) begin n_fail++; $display("FAIL rand_dregs c=%0d: got %0h/%0h want %0h/%0h", c, D_rA, D_rB, m_ra, m_rb); end
            n_checks++; if (D_valC !== m_valc || D_valP !== m_valp) begin n_fail++; $display("FAIL rand_dvals c=%0d: got %0h/%0h want %0h/%0h", c, D_valC, D_valP, m_valc, m_valp); end
            n_checks++; if (halted !== m_halted) begin n_fail++; $display("FAIL rand_halted c=%0d: got %0b want %0b", c, halted, m_halted); end
        end
        set_idle();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        #2;
        test_reset();
        test_irmovq();
        test_jxx_mispredict();
        test_load_use();
        test_ret();
        test_imem_error();
        test_ins_hlt();
        test_valp_wrap();
        test_reset_mid_stall();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
